// File: rtl/pipe_ctrl.sv
// Purpose : five-stage pipeline valid/allowin control with load-use bubbles,
//           branch flush, saturating perf counters and a sticky hang detector.
// Latency : unstalled instruction advances one stage per cycle (DS -> WS in 3).
// Backpressure: allowin chains combinationally from WS back to FS; any stage
//           whose ready_go is low holds itself and every stage behind it.
// Ports   : clk, reset (sync, active-high); fs_valid, loaduse, br_flush,
//           ex_busy, mem_wait in; fs_allowin, ds/es/ms/ws_valid, ds_flush,
//           bubble_cnt, flush_cnt, hang out.
module pipe_ctrl #(
  parameter int CNT_W      = 16,
  parameter int HANG_LIMIT = 255   // must be >= 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fs_valid,
  input  logic             loaduse,
  input  logic             br_flush,
  input  logic             ex_busy,
  input  logic             mem_wait,
  output logic             fs_allowin,
  output logic             ds_valid,
  output logic             es_valid,
  output logic             ms_valid,
  output logic             ws_valid,
  output logic             ds_flush,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             hang
);

  localparam int                 STALL_W   = $clog2(HANG_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(HANG_LIMIT);

  logic ds_valid_q, ds_valid_d;
  logic es_valid_q, es_valid_d;
  logic ms_valid_q, ms_valid_d;
  logic ws_valid_q, ws_valid_d;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic hang_q, hang_d;

  logic ds_rg, es_rg, ms_rg;
  logic ws_allowin, ms_allowin, es_allowin, ds_allowin;
  // Qualified flush: the branch in ES only redirects once it actually leaves ES.
  logic flush_qual;
  logic bubble_inc;
  logic stall;

  always_comb begin
    ds_rg = !loaduse;
    es_rg = !ex_busy;
    ms_rg = !mem_wait;

    ws_allowin = 1'b1;
    ms_allowin = !ms_valid_q | (ms_rg & ws_allowin);
    es_allowin = !es_valid_q | (es_rg & ms_allowin);
    ds_allowin = !ds_valid_q | (ds_rg & es_allowin);

    flush_qual = br_flush & es_valid_q & es_rg & ms_allowin;

    // Flush has priority over the load-use stall: DS is wrong-path, no bubble.
    bubble_inc = ds_valid_q & loaduse & es_allowin & !flush_qual;
    stall      = (es_valid_q & ex_busy) | (ms_valid_q & mem_wait);

    ds_valid_d = ds_valid_q;
    if (flush_qual)      ds_valid_d = 1'b0;
    else if (ds_allowin) ds_valid_d = fs_valid;

    es_valid_d = es_valid_q;
    if (es_allowin & flush_qual) es_valid_d = 1'b0;
    else if (es_allowin)         es_valid_d = ds_valid_q & ds_rg;

    ms_valid_d = ms_allowin ? (es_valid_q & es_rg) : ms_valid_q;
    ws_valid_d = ws_allowin ? (ms_valid_q & ms_rg) : ws_valid_q;

    bubble_cnt_d = bubble_cnt_q;
    if (bubble_inc && (bubble_cnt_q != {CNT_W{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);

    flush_cnt_d = flush_cnt_q;
    if (flush_qual && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);

    stall_cnt_d = '0;
    if (stall)
      stall_cnt_d = (stall_cnt_q == STALL_MAX) ? STALL_MAX : stall_cnt_q + STALL_W'(1);

    // Set on the edge where the count reaches the limit, i.e. after exactly
    // HANG_LIMIT consecutive stalled cycles.
    hang_d = hang_q | (stall_cnt_d == STALL_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid_q   <= 1'b0;
      es_valid_q   <= 1'b0;
      ms_valid_q   <= 1'b0;
      ws_valid_q   <= 1'b0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
      stall_cnt_q  <= '0;
      hang_q       <= 1'b0;
    end else begin
      ds_valid_q   <= ds_valid_d;
      es_valid_q   <= es_valid_d;
      ms_valid_q   <= ms_valid_d;
      ws_valid_q   <= ws_valid_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      hang_q       <= hang_d;
    end
  end

  // Fetch may always load while the pipe is being reset.
  assign fs_allowin = reset | ds_allowin;
  assign ds_flush   = flush_qual;
  assign ds_valid   = ds_valid_q;
  assign es_valid   = es_valid_q;
  assign ms_valid   = ms_valid_q;
  assign ws_valid   = ws_valid_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign hang       = hang_q;

endmodule
